// File: rtl/scontroller_pkg.sv
// Shared opcode/phase definitions for the accumulator-CPU sequence controller.
package scontroller_pkg;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] opcode_t;

    localparam opcode_t HLT = 3'd0;
    localparam opcode_t SKZ = 3'd1;
    localparam opcode_t ADD = 3'd2;
    localparam opcode_t AND = 3'd3;
    localparam opcode_t XOR = 3'd4;
    localparam opcode_t LDA = 3'd5;
    localparam opcode_t STO = 3'd6;
    localparam opcode_t JMP = 3'd7;

    localparam phase_t INST_ADDR  = 3'd0;
    localparam phase_t INST_FETCH = 3'd1;
    localparam phase_t INST_LOAD  = 3'd2;
    localparam phase_t IDLE       = 3'd3;
    localparam phase_t OP_ADDR    = 3'd4;
    localparam phase_t OP_FETCH   = 3'd5;
    localparam phase_t ALU_OP     = 3'd6;
    localparam phase_t STORE      = 3'd7;

    // Instructions that read an operand from memory into the accumulator
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/scontroller_decode.sv
// Combinational strobe decode from phase, opcode and ALU zero flag.
module scontroller_decode
    import scontroller_pkg::*;
(
    input  logic [2:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr
);

    logic aluop_s;

    assign aluop_s = is_aluop(opcode);

    // Per-phase strobe table; anything not assigned in a phase stays low
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        case (phase)
            INST_ADDR: begin
            end
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            OP_FETCH: begin
                mem_rd = aluop_s;
            end
            ALU_OP: begin
                mem_rd  = aluop_s;
                load_ac = aluop_s;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            STORE: begin
                mem_rd  = aluop_s;
                load_ac = aluop_s;
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
                mem_wr  = (opcode == STO);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/scontroller.sv
// Sequence controller top: 8-phase counter plus strobe decode.
// Optional sticky halt lock enabled by defining SCONTROLLER_HALT_LOCK_EN.
module scontroller
    import scontroller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr
);

    phase_t phase_r;
    logic   dec_mem_rd_s;
    logic   dec_load_ir_s;
    logic   dec_halt_s;
    logic   dec_inc_pc_s;
    logic   dec_load_ac_s;
    logic   dec_load_pc_s;
    logic   dec_mem_wr_s;

    scontroller_decode u_decode (
        .phase   (phase_r),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (dec_mem_rd_s),
        .load_ir (dec_load_ir_s),
        .halt    (dec_halt_s),
        .inc_pc  (dec_inc_pc_s),
        .load_ac (dec_load_ac_s),
        .load_pc (dec_load_pc_s),
        .mem_wr  (dec_mem_wr_s)
    );

`ifdef SCONTROLLER_HALT_LOCK_EN
    logic halted_r;

    // Sticky halt flag: set leaving OP_ADDR on HLT, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if ((phase_r == OP_ADDR) && (opcode == HLT)) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Phase counter; parks at OP_FETCH while halted
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= INST_ADDR;
        end else if (halted_r) begin
            phase_r <= OP_FETCH;
        end else begin
            phase_r <= phase_r + 3'd1;
        end
    end

    // While halted only the halt strobe is driven
    always_comb begin
        if (halted_r) begin
            mem_rd  = 1'b0;
            load_ir = 1'b0;
            halt    = 1'b1;
            inc_pc  = 1'b0;
            load_ac = 1'b0;
            load_pc = 1'b0;
            mem_wr  = 1'b0;
        end else begin
            mem_rd  = dec_mem_rd_s;
            load_ir = dec_load_ir_s;
            halt    = dec_halt_s;
            inc_pc  = dec_inc_pc_s;
            load_ac = dec_load_ac_s;
            load_pc = dec_load_pc_s;
            mem_wr  = dec_mem_wr_s;
        end
    end
`else
    // Free-running phase counter, wrapping 7 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= INST_ADDR;
        end else begin
            phase_r <= phase_r + 3'd1;
        end
    end

    assign mem_rd  = dec_mem_rd_s;
    assign load_ir = dec_load_ir_s;
    assign halt    = dec_halt_s;
    assign inc_pc  = dec_inc_pc_s;
    assign load_ac = dec_load_ac_s;
    assign load_pc = dec_load_pc_s;
    assign mem_wr  = dec_mem_wr_s;
`endif

endmodule

// File: tb/tb_scontroller.sv
// Scoreboard bench for scontroller: directed per-cycle vectors, monitor compares on negedge.
module tb_scontroller;
    import scontroller_pkg::*;

    // Expected vector bit order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    localparam logic [6:0] Z0 = 7'b0000000;
    localparam logic [6:0] MR = 7'b1000000;
    localparam logic [6:0] IR = 7'b0100000;
    localparam logic [6:0] HL = 7'b0010000;
    localparam logic [6:0] IP = 7'b0001000;
    localparam logic [6:0] LA = 7'b0000100;
    localparam logic [6:0] LP = 7'b0000010;
    localparam logic [6:0] MW = 7'b0000001;

    typedef struct {
        logic [6:0] exp;
        int         idx;
    } sb_entry_t;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

    sb_entry_t  sb[$];
    int         n_vec;
    int         n_err;
    int         n_push;

    scontroller dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: after the edge, drive inputs and queue this cycle's expected strobes
    task automatic cyc(input logic r, input logic [2:0] op, input logic z, input logic [6:0] e);
        sb_entry_t ent;
        @(posedge clk);
        #1;
        rst    = r;
        opcode = op;
        zero   = z;
        ent.exp = e;
        ent.idx = n_push;
        n_push++;
        sb.push_back(ent);
    endtask

    // Full instruction starting in INST_ADDR; phases 4..7 supplied by caller
    task automatic instr(input logic [2:0] op, input logic z,
                         input logic [6:0] e4, input logic [6:0] e5,
                         input logic [6:0] e6, input logic [6:0] e7);
        cyc(1'b0, op, z, Z0);
        cyc(1'b0, op, z, MR);
        cyc(1'b0, op, z, MR | IR);
        cyc(1'b0, op, z, MR | IR);
        cyc(1'b0, op, z, e4);
        cyc(1'b0, op, z, e5);
        cyc(1'b0, op, z, e6);
        cyc(1'b0, op, z, e7);
    endtask

    // Monitor: outputs are presented every cycle; pop and compare mid-cycle
    initial begin
        sb_entry_t  ent;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                act = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
                n_vec++;
                if (act !== ent.exp) begin
                    n_err++;
                    $display("FAIL vec%0d strobes: got %b expected %b", ent.idx, act, ent.exp);
                end
                n_vec++;
                if (mem_rd === 1'b1 && mem_wr === 1'b1) begin
                    n_err++;
                    $display("FAIL vec%0d rd_wr_excl: got mem_rd=1 mem_wr=1 expected not both", ent.idx);
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        n_push = 0;
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;

        // Reset held across two edges, released in the second cycle
        cyc(1'b1, 3'd0, 1'b0, Z0);
        // ADD, zero clear
        instr(ADD, 1'b0, IP, MR, MR | LA, MR | LA);
        // SKZ taken and not taken (wrap 7->0 between instructions)
        instr(SKZ, 1'b1, IP, Z0, IP, Z0);
        instr(SKZ, 1'b0, IP, Z0, Z0, Z0);
        // Store and jump
        instr(STO, 1'b0, IP, Z0, Z0, MW);
        instr(JMP, 1'b1, IP, Z0, LP, LP | IP);
        // Reset asserted in ALU_OP of an LDA
        cyc(1'b0, LDA, 1'b0, Z0);
        cyc(1'b0, LDA, 1'b0, MR);
        cyc(1'b0, LDA, 1'b0, MR | IR);
        cyc(1'b0, LDA, 1'b0, MR | IR);
        cyc(1'b0, LDA, 1'b0, IP);
        cyc(1'b0, LDA, 1'b0, MR);
        cyc(1'b1, LDA, 1'b1, MR | LA);
        // Restart from INST_ADDR after the abort, with XOR
        instr(XOR, 1'b0, IP, MR, MR | LA, MR | LA);
`ifdef SCONTROLLER_HALT_LOCK_EN
        // Halt locks at OP_FETCH with only halt asserted until reset
        cyc(1'b0, HLT, 1'b0, Z0);
        cyc(1'b0, HLT, 1'b0, MR);
        cyc(1'b0, HLT, 1'b0, MR | IR);
        cyc(1'b0, HLT, 1'b0, MR | IR);
        cyc(1'b0, HLT, 1'b0, IP | HL);
        for (int i = 0; i < 5; i++) cyc(1'b0, ADD, 1'b1, HL);
        cyc(1'b1, ADD, 1'b0, HL);
        instr(AND, 1'b0, IP, MR, MR | LA, MR | LA);
`else
        // Halt is a single pulse and sequencing continues
        instr(HLT, 1'b0, IP | HL, Z0, Z0, Z0);
        instr(AND, 1'b0, IP, MR, MR | LA, MR | LA);
`endif

        // Drain: monitor must have consumed every queued vector
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
